vcve2_vec_seq: RTL
==================

# vcve2_vec_seq

Vector element-group sequencer for the vcve2 execution stage. Accepts one vector arithmetic instruction at a time, splits the active vector length into 32-bit element groups and drives the EX block one word per group. It waits on the EX valid handshake for multi-cycle multiply/divide operations and generates vector register file write-back with tail byte enables. It sits between the ID-stage vector decode and the EX block/vector register file.

## Interface
- VLEN, 128: vector register length in bits; multiple of 32, 32..1024.
- VLW, $clog2(VLEN/8)+1: width of vl_i.
- WW, $clog2(VLEN/32): width of the word index; minimum 1.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  instruction valid; accepted only when ready_o=1.
- vl_i  in  VLW  active element count, sampled at accept.
- vsew_i  in  3  element width: 000=8b, 001=16b, 010=32b; other codes illegal. Sampled at accept.
- vd_i  in  5  destination register, sampled at accept.
- kill_i  in  1  flush from controller.
- ready_o  out  1  sequencer idle.
- vsew_o  out  3  latched SEW, drives EX vsew.
- word_idx_o  out  WW  current 32-bit word index, drives register file read offsets.
- ex_first_o  out  1  first cycle of the current word, drives alu_instr_first_cycle.
- ex_valid_i  in  1  EX result valid for the current word.
- wb_we_o  out  1  write-back strobe.
- wb_vd_o  out  5  latched vd.
- wb_be_o  out  4  byte enables for the write.
- done_o  out  1  one-cycle completion pulse.
- illegal_o  out  1  one-cycle pulse for an illegal vsew.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - ready_o=1.
  - On start_i, latch vsew, vd and the clamped vl.
  - Clamp rule: vl_eff = min(vl_i, VLEN >> (3+vsew)).
  - Compute bytes = vl_eff << vsew and nwords = ceil(bytes/4) (WW+1 bits).
  - Compute rem = bytes[1:0].
- Transitions from IDLE on accept:
  - vsew illegal: pulse illegal_o next cycle, stay IDLE, no writes.
  - vl_eff=0: go to DONE, no writes.
  - Otherwise: go to EXEC with word_idx=0.
- EXEC:
  - ex_first_o=1 in the first EXEC cycle of each word.
  - wb_we_o = ex_valid_i & ~kill_i.
  - On ex_valid_i, if word_idx = nwords-1 go to DONE; otherwise increment word_idx.
  - wb_be_o = 4'hF for non-final words.
  - Final word: wb_be_o = 4'hF if rem=0, else (1<<rem)-1.
- DONE: done_o=1 for one cycle, then IDLE.
- kill_i has priority in every state: go to IDLE next cycle. No done_o, no wb_we_o in the kill cycle, latched state discarded.
- start_i while not IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, word_idx=0.
  - ready_o=1.
  - All other outputs 0; wb_be_o=0, vsew_o=0, wb_vd_o=0.
- wb_we_o, wb_be_o and ex_first_o are combinational from state and ex_valid_i. done_o, ready_o and illegal_o are registered state decodes.
- Single-cycle EX (ex_valid_i held 1): N words take N EXEC cycles plus 1 DONE cycle. Accept-to-done_o latency is N+1 cycles.
- Multi-cycle EX: EXEC holds word_idx and outputs stable until ex_valid_i. ex_first_o is high only in the first waiting cycle.
- Back-to-back: the next start_i is accepted in the cycle after DONE, when ready_o=1.
- Reset asserted mid-instruction: immediate return to reset values, with no further write strobes.

## Configuration
- VCVE2_VSEQ_TAIL_UNDISTURBED_EN:
  - Defined: the final partial word uses the rem-derived byte enables, so tail bytes are undisturbed.
  - Undefined: wb_be_o=4'hF on every write (tail-agnostic), and rem logic is removed.

## Test plan
- VLEN=128, vsew=000, vl=5, ex_valid_i=1:
  - 2 writes, word_idx 0 then 1.
  - be 4'hF then 4'h1 with the macro (4'hF without).
  - done_o 3 cycles after accept.
- vsew=010, vl=9 (clamped to 4): 4 writes, all be=4'hF, word_idx 0..3, done_o once.
- vsew=001, vl=3, ex_valid_i delayed 3 cycles per word:
  - ex_first_o high only in the first cycle of each word.
  - Writes with be 4'hF then 4'h3.
- vl=0: no wb_we_o, done_o one cycle after accept. vsew=011: illegal_o pulse, no done_o, ready_o stays 1.
- kill_i asserted during word 1 of a 4-word op: no write in the kill cycle, no done_o, ready_o=1 next cycle, and a new start is accepted cleanly.
- rst_i pulsed mid-EXEC:
  - Asynchronous return to reset values.
  - start_i during busy is ignored, with no state change.

Source files
------------

// File: rtl/vcve2_vec_seq_if.sv
// Vector element-group sequencer interface.
// Groups the ID-stage issue signals, the EX handshake and the register file write-back
// of vcve2_vec_seq. The _i/_o suffixes are from the sequencer's point of view.
//   slave  : the sequencer (issue/EX inputs in, write-back/status outputs out)
//   master : the issuing side (controller, EX block model, testbench)
interface vcve2_vec_seq_if #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned VLW  = $clog2(VLEN / 8) + 1,
    parameter int unsigned WW   = (VLEN > 32) ? $clog2(VLEN / 32) : 1
);
    logic           start_i;
    logic [VLW-1:0] vl_i;
    logic [2:0]     vsew_i;
    logic [4:0]     vd_i;
    logic           kill_i;
    logic           ready_o;
    logic [2:0]     vsew_o;
    logic [WW-1:0]  word_idx_o;
    logic           ex_first_o;
    logic           ex_valid_i;
    logic           wb_we_o;
    logic [4:0]     wb_vd_o;
    logic [3:0]     wb_be_o;
    logic           done_o;
    logic           illegal_o;

    modport slave (
        input  start_i, vl_i, vsew_i, vd_i, kill_i, ex_valid_i,
        output ready_o, vsew_o, word_idx_o, ex_first_o, wb_we_o, wb_vd_o, wb_be_o,
               done_o, illegal_o
    );

    modport master (
        output start_i, vl_i, vsew_i, vd_i, kill_i, ex_valid_i,
        input  ready_o, vsew_o, word_idx_o, ex_first_o, wb_we_o, wb_vd_o, wb_be_o,
               done_o, illegal_o
    );
endinterface

// File: rtl/vcve2_vec_seq.sv
// Vector element-group sequencer for the vcve2 execution stage.
// Accepts one vector instruction, clamps vl to VLEN/SEW, splits the active bytes into 32-bit
// words and steps the EX block one word at a time, waiting on ex_valid_i for multi-cycle ops.
// Each completed word produces a register file write strobe with byte enables.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   vseq_io  : vcve2_vec_seq_if.slave (issue, kill, EX handshake, write-back, status)
// Build option:
//   VCVE2_VSEQ_TAIL_UNDISTURBED_EN : final partial word writes only its active bytes;
//   when undefined every write enables all four bytes (tail-agnostic).
module vcve2_vec_seq #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned VLW  = $clog2(VLEN / 8) + 1,
    parameter int unsigned WW   = (VLEN > 32) ? $clog2(VLEN / 32) : 1
) (
    input logic              clk_i,
    input logic              rst_i,
    vcve2_vec_seq_if.slave   vseq_io
);
    // One spare bit so bytes + 3 never wraps.
    localparam int unsigned BW = VLW + 1;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e         state_q;
    logic [WW-1:0]  word_idx_q;
    logic [WW-1:0]  last_idx_q;
    logic           first_q;
    logic [2:0]     vsew_q;
    logic [4:0]     vd_q;
    logic           ready_q;
    logic           done_q;
    logic           illegal_q;
`ifdef VCVE2_VSEQ_TAIL_UNDISTURBED_EN
    logic [1:0]     rem_q;
`endif

    // Accept-time decode of the incoming instruction.
    logic           sew_legal;
    logic [VLW-1:0] max_elems;
    logic [VLW-1:0] vl_eff;
    logic [BW-1:0]  bytes;
    logic [BW-1:0]  nwords;
    logic [WW-1:0]  last_idx;

    always_comb begin
        sew_legal = ~vseq_io.vsew_i[2] & (vseq_io.vsew_i[1:0] != 2'b11);
        case (vseq_io.vsew_i[1:0])
            2'b01:   max_elems = VLW'(VLEN / 16);
            2'b10:   max_elems = VLW'(VLEN / 32);
            default: max_elems = VLW'(VLEN / 8);
        endcase
        vl_eff   = (vseq_io.vl_i < max_elems) ? vseq_io.vl_i : max_elems;
        bytes    = BW'(vl_eff) << vseq_io.vsew_i[1:0];
        nwords   = (bytes + BW'(3)) >> 2;
        // Only meaningful when nwords != 0, which is the only case it is latched for.
        last_idx = WW'(nwords - BW'(1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            word_idx_q <= '0;
            last_idx_q <= '0;
            first_q    <= 1'b0;
            vsew_q     <= 3'b000;
            vd_q       <= 5'd0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef VCVE2_VSEQ_TAIL_UNDISTURBED_EN
            rem_q      <= 2'b00;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (vseq_io.kill_i) begin
                // Flush wins over everything, including a pending accept.
                state_q    <= StIdle;
                word_idx_q <= '0;
                last_idx_q <= '0;
                first_q    <= 1'b0;
                vsew_q     <= 3'b000;
                vd_q       <= 5'd0;
                ready_q    <= 1'b1;
`ifdef VCVE2_VSEQ_TAIL_UNDISTURBED_EN
                rem_q      <= 2'b00;
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        if (vseq_io.start_i) begin
                            if (!sew_legal) begin
                                illegal_q <= 1'b1;
                            end else begin
                                vsew_q     <= vseq_io.vsew_i;
                                vd_q       <= vseq_io.vd_i;
                                last_idx_q <= last_idx;
                                word_idx_q <= '0;
                                ready_q    <= 1'b0;
`ifdef VCVE2_VSEQ_TAIL_UNDISTURBED_EN
                                rem_q      <= bytes[1:0];
`endif
                                if (vl_eff == '0) begin
                                    state_q <= StDone;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= StExec;
                                    first_q <= 1'b1;
                                end
                            end
                        end
                    end
                    StExec: begin
                        if (vseq_io.ex_valid_i) begin
                            if (word_idx_q == last_idx_q) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                                first_q <= 1'b0;
                            end else begin
                                word_idx_q <= word_idx_q + WW'(1);
                                first_q    <= 1'b1;
                            end
                        end else begin
                            first_q <= 1'b0;
                        end
                    end
                    StDone: begin
                        state_q    <= StIdle;
                        word_idx_q <= '0;
                        ready_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    logic in_exec;
    logic [3:0] be;

    assign in_exec = (state_q == StExec);

    always_comb begin
        be = 4'h0;
        if (in_exec) begin
            be = 4'hF;
`ifdef VCVE2_VSEQ_TAIL_UNDISTURBED_EN
            if ((word_idx_q == last_idx_q) && (rem_q != 2'b00)) begin
                be = (4'h1 << rem_q) - 4'h1;
            end
`endif
        end
    end

    assign vseq_io.ready_o    = ready_q;
    assign vseq_io.vsew_o     = vsew_q;
    assign vseq_io.word_idx_o = word_idx_q;
    assign vseq_io.ex_first_o = first_q & in_exec;
    assign vseq_io.wb_we_o    = in_exec & vseq_io.ex_valid_i & ~vseq_io.kill_i;
    assign vseq_io.wb_vd_o    = vd_q;
    assign vseq_io.wb_be_o    = be;
    assign vseq_io.done_o     = done_q;
    assign vseq_io.illegal_o  = illegal_q;
endmodule
